// File: rtl/cplx_pkg.sv
// Shared fixed-point definitions for the complex-plane raster source and evaluator.
// Q4.12 component format, common constants, complex pair typedef and source FSM states.
package cplx_pkg;

   localparam int DW        = 16;
   localparam int FRAC_BITS = 12;

   localparam logic signed [DW-1:0] Q_M2_0     = 16'shE000;
   localparam logic signed [DW-1:0] Q_P1_0     = 16'sh1000;
   localparam logic signed [DW-1:0] Q_STEP_DEF = 16'sh0010;

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } cplx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } p2z_state_e;

endpackage

// File: rtl/pixel_to_complex_if.sv
// Streaming beat from the raster source to the evaluator: valid/ready plus z and pixel position.
interface pixel_to_complex_if #(
   parameter int DW = 16,
   parameter int XW = 10,
   parameter int YW = 9
) ();

   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] z_re;
   logic signed [DW-1:0] z_im;
   logic [XW-1:0]        pix_x;
   logic [YW-1:0]        pix_y;
   logic                 sof;
   logic                 eol;
   logic                 eof;

   modport master (
      output m_valid, z_re, z_im, pix_x, pix_y, sof, eol, eof,
      input  m_ready
   );

   modport slave (
      input  m_valid, z_re, z_im, pix_x, pix_y, sof, eol, eof,
      output m_ready
   );

endinterface

// File: rtl/pixel_to_complex_raster_counter.sv
// Column/line counters for the raster walk; advance steps one pixel, wrapping at frame end.
module raster_counter #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XW     = 10,
   parameter int YW     = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_advance,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_last_x,
   output logic          o_last_y
);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          w_last_x;
   logic          w_last_y;

   assign w_last_x = (r_x == XW'(WIDTH - 1));
   assign w_last_y = (r_y == YW'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_advance) begin
         if (w_last_x) begin
            r_x <= '0;
            r_y <= w_last_y ? '0 : r_y + YW'(1);
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

   assign o_x      = r_x;
   assign o_y      = r_y;
   assign o_last_x = w_last_x;
   assign o_last_y = w_last_y;

endmodule

// File: rtl/pixel_to_complex.sv
// Raster scan source: walks a WIDTH x HEIGHT grid and streams the matching Q4.12 point z.
// Optional PIX2Z_PAN_EN adds runtime origin/stride inputs latched at each frame start.
module pixel_to_complex
   import cplx_pkg::*;
#(
   parameter int                   WIDTH      = 640,
   parameter int                   HEIGHT     = 480,
   parameter int                   DW         = cplx_pkg::DW,
   parameter logic signed [DW-1:0] X_START    = Q_M2_0,
   parameter logic signed [DW-1:0] Y_START    = Q_P1_0,
   parameter logic signed [DW-1:0] STEP       = Q_STEP_DEF,
   parameter bit                   CONTINUOUS = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
`ifdef PIX2Z_PAN_EN
   input  logic signed [DW-1:0] x_start_in,
   input  logic signed [DW-1:0] y_start_in,
   input  logic signed [DW-1:0] step_in,
`endif
   pixel_to_complex_if.master   m
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   function automatic logic signed [DW-1:0] wrap_add(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
      return a + b;
   endfunction

   function automatic logic signed [DW-1:0] wrap_sub(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
      return a - b;
   endfunction

   p2z_state_e           r_state;
   p2z_state_e           w_state_nxt;
   logic signed [DW-1:0] r_zre;
   logic signed [DW-1:0] r_zim;
   logic [XW-1:0]        w_x;
   logic [YW-1:0]        w_y;
   logic                 w_last_x;
   logic                 w_last_y;
   logic                 w_run;
   logic                 w_xfer;
   logic                 w_start_frame;
   logic                 w_wrap;
   logic                 w_latch;
   logic signed [DW-1:0] w_ld_x0;
   logic signed [DW-1:0] w_ld_y0;
   logic signed [DW-1:0] w_x0;
   logic signed [DW-1:0] w_step;

   assign w_run         = (r_state == ST_RUN);
   assign w_xfer        = w_run & m.m_ready;
   assign w_start_frame = (r_state == ST_IDLE) & start;
   assign w_wrap        = w_xfer & w_last_x & w_last_y;
   assign w_latch       = w_start_frame | (w_wrap & CONTINUOUS);

   // Origin and stride are frozen per frame so mid-frame input changes cannot skew the grid.
`ifdef PIX2Z_PAN_EN
   logic signed [DW-1:0] r_x0;
   logic signed [DW-1:0] r_step;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x0   <= X_START;
         r_step <= STEP;
      end else if (w_latch) begin
         r_x0   <= x_start_in;
         r_step <= step_in;
      end
   end

   assign w_ld_x0 = x_start_in;
   assign w_ld_y0 = y_start_in;
   assign w_x0    = r_x0;
   assign w_step  = r_step;
`else
   assign w_ld_x0 = X_START;
   assign w_ld_y0 = Y_START;
   assign w_x0    = X_START;
   assign w_step  = STEP;
`endif

   raster_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .XW     (XW),
      .YW     (YW)
   ) u_raster (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_start_frame),
      .i_advance (w_xfer),
      .o_x       (w_x),
      .o_y       (w_y),
      .o_last_x  (w_last_x),
      .o_last_y  (w_last_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_wrap && !CONTINUOUS) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Incremental accumulation replaces a per-pixel multiply; overflow wraps by design.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_zre <= '0;
         r_zim <= '0;
      end else if (w_latch) begin
         r_zre <= w_ld_x0;
         r_zim <= w_ld_y0;
      end else if (w_xfer) begin
         if (!w_last_x) begin
            r_zre <= wrap_add(r_zre, w_step);
         end else if (!w_last_y) begin
            r_zre <= w_x0;
            r_zim <= wrap_sub(r_zim, w_step);
         end
      end
   end

   assign busy      = w_run;
   assign m.m_valid = w_run;
   assign m.z_re    = r_zre;
   assign m.z_im    = r_zim;
   assign m.pix_x   = w_x;
   assign m.pix_y   = w_y;
   assign m.sof     = w_run & (w_x == '0) & (w_y == '0);
   assign m.eol     = w_run & w_last_x;
   assign m.eof     = w_run & w_last_x & w_last_y;

endmodule

// File: tb/tb_pixel_to_complex.sv
// Directed bench for pixel_to_complex on a 4x3 grid: single-shot and continuous instances.
// Exercises PIX2Z_PAN_EN panning when that macro is defined for the build.
module tb_pixel_to_complex;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic busy0;
   logic busy1;
   int   errors = 0;
   int   checks = 0;

   pixel_to_complex_if #(.DW(16), .XW(2), .YW(2)) if0 ();
   pixel_to_complex_if #(.DW(16), .XW(2), .YW(2)) if1 ();

`ifdef PIX2Z_PAN_EN
   logic signed [15:0] xs0 = 16'shE000;
   logic signed [15:0] ys0 = 16'sh1000;
   logic signed [15:0] st0 = 16'sh0800;
   logic signed [15:0] xs1 = 16'shE000;
   logic signed [15:0] ys1 = 16'sh1000;
   logic signed [15:0] st1 = 16'sh0800;
`endif

   pixel_to_complex #(
      .WIDTH(4), .HEIGHT(3), .DW(16), .X_START(16'shE000), .Y_START(16'sh1000),
      .STEP(16'sh0800), .CONTINUOUS(1'b0)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
`ifdef PIX2Z_PAN_EN
      .x_start_in(xs0), .y_start_in(ys0), .step_in(st0),
`endif
      .m(if0)
   );

   pixel_to_complex #(
      .WIDTH(4), .HEIGHT(3), .DW(16), .X_START(16'shE000), .Y_START(16'sh1000),
      .STEP(16'sh0800), .CONTINUOUS(1'b1)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
`ifdef PIX2Z_PAN_EN
      .x_start_in(xs1), .y_start_in(ys1), .step_in(st1),
`endif
      .m(if1)
   );

   always #5 clk = ~clk;

   // Observation vector: {valid, busy, z_re, z_im, x, y, sof, eol, eof}
   logic [40:0] obs0;
   logic [40:0] obs1;
   assign obs0 = {if0.m_valid, busy0, if0.z_re, if0.z_im, if0.pix_x, if0.pix_y, if0.sof, if0.eol, if0.eof};
   assign obs1 = {if1.m_valid, busy1, if1.z_re, if1.z_im, if1.pix_x, if1.pix_y, if1.sof, if1.eol, if1.eof};

   // Expected beat i of a frame sequence (i may span several frames)
   function automatic logic [40:0] exp_beat(input int i);
      int x, y;
      logic [15:0] re, im;
      x  = i % 4;
      y  = (i / 4) % 3;
      re = 16'hE000 + 16'(x * 2048);
      im = 16'h1000 - 16'(y * 2048);
      return {1'b1, 1'b1, re, im, 2'(x), 2'(y), (x == 0 && y == 0), (x == 3), (x == 3 && y == 2)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if0.m_ready = 1'b1;
      if1.m_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (obs0 !== 41'd0) begin
         errors++;
         $display("FAIL reset_u0: got %h expected %h", obs0, 41'd0);
      end
      checks++;
      if (obs1 !== 41'd0) begin
         errors++;
         $display("FAIL reset_u1: got %h expected %h", obs1, 41'd0);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs0 !== 41'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h expected %h", obs0, 41'd0);
      end
   endtask

   task automatic test_frame();
      if0.m_ready = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (obs0 !== exp_beat(i)) begin
            errors++;
            $display("FAIL frame_beat%0d: got %h expected %h", i, obs0, exp_beat(i));
         end
         tick();
      end
      checks++;
      if (obs0[40:39] !== 2'b00) begin
         errors++;
         $display("FAIL frame_end_idle: valid/busy got %b expected 00", obs0[40:39]);
      end
   endtask

   task automatic test_backpressure();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 1) begin
            if0.m_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               checks++;
               if (obs0 !== exp_beat(1)) begin
                  errors++;
                  $display("FAIL bp_hold%0d: got %h expected %h", s, obs0, exp_beat(1));
               end
            end
            if0.m_ready = 1'b1;
         end
         checks++;
         if (obs0 !== exp_beat(i)) begin
            errors++;
            $display("FAIL bp_beat%0d: got %h expected %h", i, obs0, exp_beat(i));
         end
         tick();
      end
      checks++;
      if (obs0[40:39] !== 2'b00) begin
         errors++;
         $display("FAIL bp_end_idle: valid/busy got %b expected 00", obs0[40:39]);
      end
   endtask

   task automatic test_reset_mid_frame();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (obs0 !== exp_beat(5)) begin
         errors++;
         $display("FAIL mid_beat6: got %h expected %h", obs0, exp_beat(5));
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (obs0 !== 41'd0) begin
         errors++;
         $display("FAIL mid_reset: got %h expected %h", obs0, 41'd0);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs0 !== 41'd0) begin
         errors++;
         $display("FAIL mid_stay_idle: got %h expected %h", obs0, 41'd0);
      end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      checks++;
      if (obs0 !== exp_beat(0)) begin
         errors++;
         $display("FAIL mid_restart: got %h expected %h", obs0, exp_beat(0));
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_start_ignored();
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (obs0 !== exp_beat(i)) begin
            errors++;
            $display("FAIL ign_beat%0d: got %h expected %h", i, obs0, exp_beat(i));
         end
         if (i == 5 || i == 11) start0 = 1'b1;
         tick();
         start0 = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs0[40:39] !== 2'b00) begin
            errors++;
            $display("FAIL ign_idle%0d: valid/busy got %b expected 00", k, obs0[40:39]);
         end
         tick();
      end
   endtask

   task automatic test_continuous();
      if1.m_ready = 1'b1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 25; i++) begin
         checks++;
         if (obs1 !== exp_beat(i)) begin
            errors++;
            $display("FAIL cont_beat%0d: got %h expected %h", i, obs1, exp_beat(i));
         end
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (obs1 !== 41'd0) begin
         errors++;
         $display("FAIL cont_reset: got %h expected %h", obs1, 41'd0);
      end
      tick();
   endtask

`ifdef PIX2Z_PAN_EN
   task automatic test_pan();
      logic [15:0] exp_re [3];
      exp_re[0] = 16'h0000;
      exp_re[1] = 16'h0400;
      exp_re[2] = 16'h0800;
      xs0 = 16'sh0000;
      st0 = 16'sh0400;
      if0.m_ready = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (if0.z_re !== exp_re[i]) begin
            errors++;
            $display("FAIL pan_beat%0d: z_re got %h expected %h", i, if0.z_re, exp_re[i]);
         end
         if (i == 0) st0 = 16'sh0100;
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask
`endif

   initial begin
      if0.m_ready = 1'b0;
      if1.m_ready = 1'b0;
      test_reset();
      test_frame();
      test_backpressure();
      test_reset_mid_frame();
      test_start_ignored();
      test_continuous();
`ifdef PIX2Z_PAN_EN
      test_pan();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
